// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: takes one command from a req/ack stream,
// runs one read or write on the bus, and returns one response (data or timeout error).
module wb_cmd_master #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   t_cmd_adr,
    input  logic [DW-1:0]   t_cmd_dat,
    input  logic [DW/8-1:0] t_cmd_sel,
    input  logic            t_cmd_we,
    input  logic            t_cmd_req,
    output logic            t_cmd_ack,
    output logic [DW-1:0]   i_rsp_dat,
    output logic            i_rsp_err,
    output logic            i_rsp_req,
    input  logic            i_rsp_ack,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    output logic [7:0]      err_cnt
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          cmd_fire;
    logic          rsp_fire;
    logic          timeout_hit;

    // armed holds t_cmd_ack low until the first clock edge after reset release.
    assign t_cmd_ack   = armed && (state == S_IDLE);
    assign i_rsp_req   = (state == S_RSP);
    assign wb_stb_o    = wb_cyc_o;
    assign cmd_fire    = t_cmd_req && t_cmd_ack;
    assign rsp_fire    = i_rsp_req && i_rsp_ack;
    assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make the update order matter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            armed     <= 1'b0;
            cnt       <= '0;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_sel_o  <= '0;
            wb_dat_o  <= '0;
            i_rsp_dat <= '0;
            i_rsp_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        wb_adr_o <= t_cmd_adr;
                        wb_dat_o <= t_cmd_dat;
                        wb_sel_o <= t_cmd_sel;
                        wb_we_o  <= t_cmd_we;
                        wb_cyc_o <= 1'b1;
                        cnt      <= '0;
                        state    <= S_BUS;
                    end
                end
                S_BUS: begin
                    // An ack on the same edge as the timeout still completes the transfer.
                    if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        i_rsp_dat <= wb_we_o ? '0 : wb_dat_i;
                        i_rsp_err <= 1'b0;
                        state     <= S_RSP;
                    end else if (timeout_hit) begin
                        wb_cyc_o  <= 1'b0;
                        i_rsp_dat <= '0;
                        i_rsp_err <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state     <= S_RSP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_fire) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master (TIMEOUT=8): table of transfers with a bench-side slave,
// plus hand sequences for response back-pressure, stray acks, saturation and mid-bus reset.
module tb_wb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [AW-1:0]   t_cmd_adr;
    logic [DW-1:0]   t_cmd_dat;
    logic [DW/8-1:0] t_cmd_sel;
    logic            t_cmd_we;
    logic            t_cmd_req;
    logic            t_cmd_ack;
    logic [DW-1:0]   i_rsp_dat;
    logic            i_rsp_err;
    logic            i_rsp_req;
    logic            i_rsp_ack;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic [7:0]      err_cnt;

    wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .t_cmd_adr(t_cmd_adr), .t_cmd_dat(t_cmd_dat), .t_cmd_sel(t_cmd_sel),
        .t_cmd_we(t_cmd_we), .t_cmd_req(t_cmd_req), .t_cmd_ack(t_cmd_ack),
        .i_rsp_dat(i_rsp_dat), .i_rsp_err(i_rsp_err), .i_rsp_req(i_rsp_req),
        .i_rsp_ack(i_rsp_ack),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          lat;      // slave ack in this cyc-high cycle (0-based); -1 = never
        int          hold;     // cycles i_rsp_ack stays low in RSP
        logic [31:0] rdata;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cyc;  // expected number of cycles with cyc high
    } vec_t;

    vec_t vecs[7];
    int   n_pass  = 0;
    int   n_total = 0;
    int   exp_errs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input int lat, input int hold,
                                input logic [31:0] rdata, input logic [31:0] exp_dat,
                                input logic exp_err, input int exp_cyc);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.lat = lat; v.hold = hold;
        v.rdata = rdata; v.exp_dat = exp_dat; v.exp_err = exp_err; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int cyc_n;
        bit done;
        @(negedge clk);
        check("cmd_ack_idle", t_cmd_ack, 1);
        t_cmd_adr = v.adr;
        t_cmd_dat = v.dat;
        t_cmd_sel = v.sel;
        t_cmd_we  = v.we;
        t_cmd_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_cmd_req = 1'b0;
        t_cmd_adr = '0;
        t_cmd_dat = ~v.dat;
        t_cmd_sel = ~v.sel;
        t_cmd_we  = ~v.we;
        cyc_n = 0;
        done  = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (!wb_cyc_o) begin
                done = 1;
            end else begin
                cyc_n++;
                check("bus_adr", wb_adr_o, v.adr);
                check("bus_dat", wb_dat_o, v.dat);
                check("bus_sel", wb_sel_o, v.sel);
                check("bus_we", wb_we_o, v.we);
                check("bus_stb", wb_stb_o, 1);
                check("bus_cmd_ack", t_cmd_ack, 0);
                if (k == v.lat) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = v.rdata;
                end
                @(posedge clk);
                @(negedge clk);
                wb_ack_i = 1'b0;
                wb_dat_i = 32'h0BAD_0BAD;
            end
        end
        check("bus_done", done, 1);
        check("cyc_cycles", cyc_n, v.exp_cyc);
        if (v.exp_err && exp_errs < 255) exp_errs++;
        check("rsp_req", i_rsp_req, 1);
        check("rsp_dat", i_rsp_dat, v.exp_dat);
        check("rsp_err", i_rsp_err, v.exp_err);
        check("err_cnt", err_cnt, exp_errs);
        for (int h = 0; h < v.hold; h++) begin
            if (h == 0) begin
                wb_ack_i = 1'b1;
                wb_dat_i = 32'h5555_AAAA;
            end
            @(posedge clk);
            @(negedge clk);
            wb_ack_i = 1'b0;
            check("hold_req", i_rsp_req, 1);
            check("hold_dat", i_rsp_dat, v.exp_dat);
            check("hold_err", i_rsp_err, v.exp_err);
            check("hold_cmd_ack", t_cmd_ack, 0);
            check("hold_cyc", wb_cyc_o, 0);
        end
        i_rsp_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rsp_ack = 1'b0;
        check("post_rsp_idle", t_cmd_ack, 1);
        check("post_rsp_req", i_rsp_req, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(1'b1, 32'h3000_0004, 32'h0000_1234, 4'hF,  0,  0, 32'hAAAA_5555, 32'h0, 1'b0, 1);
        vecs[1] = mk(1'b0, 32'h3000_0008, 32'h1111_2222, 4'hF,  5, 10, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 6);
        vecs[2] = mk(1'b0, 32'h3000_0010, 32'h0,         4'h3, -1,  0, 32'h0, 32'h0, 1'b1, 8);
        vecs[3] = mk(1'b0, 32'h3000_0014, 32'h0,         4'hF,  7,  0, 32'h1234_5678, 32'h1234_5678, 1'b0, 8);
        vecs[4] = mk(1'b1, 32'h3000_000C, 32'hDEAD_BEEF, 4'h5,  2,  1, 32'h7777_7777, 32'h0, 1'b0, 3);
        vecs[5] = mk(1'b1, 32'h3000_0020, 32'h0F0F_0F0F, 4'hC, -1,  0, 32'h0, 32'h0, 1'b1, 8);
        vecs[6] = mk(1'b0, 32'h3000_0000, 32'h0,         4'h1,  0,  0, 32'h0000_00A5, 32'h0000_00A5, 1'b0, 1);

        reset_n   = 1'b0;
        t_cmd_adr = '0; t_cmd_dat = '0; t_cmd_sel = '0; t_cmd_we = 1'b0; t_cmd_req = 1'b0;
        i_rsp_ack = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ack", t_cmd_ack, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_rsp_req", i_rsp_req, 0);
        check("rst_outs", {wb_we_o, wb_adr_o, wb_sel_o, i_rsp_err}, 0);
        check("rst_rsp_dat", {wb_dat_o, i_rsp_dat}, 0);
        check("rst_err_cnt", err_cnt, 0);
        reset_n = 1'b1;
        #1;
        check("release_cmd_ack_low", t_cmd_ack, 0);
        @(negedge clk);
        check("first_edge_cmd_ack", t_cmd_ack, 1);

        // Stray ack while idle must not start anything.
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        wb_ack_i = 1'b0;
        check("idle_ack_req", i_rsp_req, 0);
        check("idle_ack_cmd_ack", t_cmd_ack, 1);
        check("idle_ack_cyc", wb_cyc_o, 0);

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        for (int i = 0; i < 300; i++) run_txn(vecs[2]);
        check("err_cnt_saturated", err_cnt, 255);

        // Reset in the middle of a bus cycle drops it without a clock edge.
        @(negedge clk);
        t_cmd_adr = 32'h3000_0018; t_cmd_we = 1'b0; t_cmd_sel = 4'hF; t_cmd_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_cmd_req = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_cyc", wb_cyc_o, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_cyc", wb_cyc_o, 0);
        check("async_stb", wb_stb_o, 0);
        check("async_rsp_req", i_rsp_req, 0);
        check("async_cmd_ack", t_cmd_ack, 0);
        check("async_err_cnt", err_cnt, 0);
        exp_errs = 0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rerelease_cmd_ack_low", t_cmd_ack, 0);
        run_txn(vecs[6]);
        run_txn(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
